execute_ctrl: RTL and testbench



---
 rtl/execute_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_execute_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_ctrl.sv
// Execute-stage controller for the pipelined Y86-64 core: E register, CC register,
// ALU chain, condition evaluation and E->M register, plus a halt FSM on faulting instructions.
module execute_ctrl #(
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  d_icode,
    input  logic [3:0]  d_ifun,
    input  logic [63:0] d_valA,
    input  logic [63:0] d_valB,
    input  logic [63:0] d_valC,
    input  logic [3:0]  d_dstE,
    input  logic [3:0]  d_dstM,
    input  logic [1:0]  d_stat,
    input  logic        e_stall,
    input  logic        e_bubble,
    input  logic        m_bubble,
    input  logic        m_exc,
    input  logic        w_exc,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic [3:0]  M_icode,
    output logic [3:0]  M_ifun,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [1:0]  M_stat,
    output logic [2:0]  cc,
    output logic        halted
);

    localparam logic [1:0] StatAok = 2'd0;

    typedef enum logic [0:0] {StRun, StHalted} state_e;
    state_e state_q, state_d;

    logic [3:0]  e_icode_q, e_ifun_q, e_dste_q, e_dstm_q;
    logic [63:0] e_vala_q, e_valb_q, e_valc_q;
    logic [1:0]  e_stat_q;

    logic [3:0]  m_icode_q, m_ifun_q, m_dste_q, m_dstm_q;
    logic [63:0] m_vale_q, m_vala_q;
    logic [1:0]  m_stat_q;
    logic        m_cnd_q;

    logic [2:0]  cc_q, cc_d;

    logic [63:0] alu_a, alu_b, alu_res;
    logic [1:0]  alu_fun;
    logic        zf, sf, of, cnd, cc_we, e_load_bubble, m_load_bubble;

    assign e_load_bubble = e_bubble || (state_q == StHalted);
    assign m_load_bubble = m_bubble || (state_q == StHalted);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_icode_q <= NOP_ICODE;
            e_ifun_q  <= 4'h0;
            e_vala_q  <= 64'h0;
            e_valb_q  <= 64'h0;
            e_valc_q  <= 64'h0;
            e_dste_q  <= RNONE;
            e_dstm_q  <= RNONE;
            e_stat_q  <= StatAok;
        end else if (e_stall) begin
            e_icode_q <= e_icode_q;
        end else if (e_load_bubble) begin
            e_icode_q <= NOP_ICODE;
            e_ifun_q  <= 4'h0;
            e_vala_q  <= 64'h0;
            e_valb_q  <= 64'h0;
            e_valc_q  <= 64'h0;
            e_dste_q  <= RNONE;
            e_dstm_q  <= RNONE;
            e_stat_q  <= StatAok;
        end else begin
            e_icode_q <= d_icode;
            e_ifun_q  <= d_ifun;
            e_vala_q  <= d_valA;
            e_valb_q  <= d_valB;
            e_valc_q  <= d_valC;
            e_dste_q  <= d_dstE;
            e_dstm_q  <= d_dstM;
            e_stat_q  <= d_stat;
        end
    end

    always_comb begin
        alu_a = 64'h0;
        unique case (e_icode_q)
            4'h2, 4'h6:       alu_a = e_vala_q;
            4'h3, 4'h4, 4'h5: alu_a = e_valc_q;
            4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       alu_a = 64'd8;
            default:          alu_a = 64'h0;
        endcase
        alu_b = 64'h0;
        unique case (e_icode_q)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = e_valb_q;
            default:                                  alu_b = 64'h0;
        endcase
        alu_fun = (e_icode_q == 4'h6) ? e_ifun_q[1:0] : 2'd0;
    end

    always_comb begin
        alu_res = 64'h0;
        of      = 1'b0;
        unique case (alu_fun)
            2'd0: begin
                alu_res = alu_b + alu_a;
                of = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
            end
            2'd1: begin
                alu_res = alu_b - alu_a;
                of = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
            end
            2'd2:    alu_res = alu_b & alu_a;
            default: alu_res = alu_b ^ alu_a;
        endcase
        zf = (alu_res == 64'h0);
        sf = alu_res[63];
    end

    // Conditions use the registered flags, so an OPq result is visible one cycle later.
    always_comb begin
        cnd = 1'b0;
        unique case (e_ifun_q)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2:    cnd = cc_q[1] ^ cc_q[0];
            4'h3:    cnd = cc_q[2];
            4'h4:    cnd = !cc_q[2];
            4'h5:    cnd = !(cc_q[1] ^ cc_q[0]);
            4'h6:    cnd = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
            default: cnd = 1'b0;
        endcase
    end

    assign e_valE = alu_res;
    assign e_dstE = ((e_icode_q == 4'h2) && !cnd) ? RNONE : e_dste_q;

    assign cc_we = (e_icode_q == 4'h6) && (e_stat_q == StatAok) && !m_exc && !w_exc &&
                   (state_q == StRun);
    assign cc_d  = cc_we ? {zf, sf, of} : cc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else begin
            cc_q <= cc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_icode_q <= NOP_ICODE;
            m_ifun_q  <= 4'h0;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= 64'h0;
            m_vala_q  <= 64'h0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
            m_stat_q  <= StatAok;
        end else if (m_load_bubble) begin
            m_icode_q <= NOP_ICODE;
            m_ifun_q  <= 4'h0;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= 64'h0;
            m_vala_q  <= 64'h0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
            m_stat_q  <= StatAok;
        end else begin
            m_icode_q <= e_icode_q;
            m_ifun_q  <= e_ifun_q;
            m_cnd_q   <= cnd;
            m_vale_q  <= alu_res;
            m_vala_q  <= e_vala_q;
            m_dste_q  <= e_dstE;
            m_dstm_q  <= e_dstm_q;
            m_stat_q  <= e_stat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (!m_load_bubble && (e_stat_q != StatAok)) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        halted = (state_q == StHalted);
    end

    assign M_icode = m_icode_q;
    assign M_ifun  = m_ifun_q;
    assign M_Cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;
    assign M_stat  = m_stat_q;
    assign cc      = cc_q;

endmodule

// File: tb/tb_execute_ctrl.sv
// Directed bench for execute_ctrl: ALU/flag results, condition codes, stall/bubble
// handling, halt freeze and asynchronous reset.
module tb_execute_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB, d_valC;
    logic [1:0]  d_stat;
    logic        e_stall, e_bubble, m_bubble, m_exc, w_exc;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_icode, M_ifun, M_dstE, M_dstM;
    logic        M_Cnd, halted;
    logic [1:0]  M_stat;
    logic [2:0]  cc;

    int errors = 0;
    int checks = 0;

    execute_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_icode  (d_icode),
        .d_ifun   (d_ifun),
        .d_valA   (d_valA),
        .d_valB   (d_valB),
        .d_valC   (d_valC),
        .d_dstE   (d_dstE),
        .d_dstM   (d_dstM),
        .d_stat   (d_stat),
        .e_stall  (e_stall),
        .e_bubble (e_bubble),
        .m_bubble (m_bubble),
        .m_exc    (m_exc),
        .w_exc    (w_exc),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .M_icode  (M_icode),
        .M_ifun   (M_ifun),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .M_stat   (M_stat),
        .cc       (cc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] dste, input logic [1:0] stat);
        d_icode = icode;
        d_ifun  = ifun;
        d_valA  = va;
        d_valB  = vb;
        d_valC  = 64'h0;
        d_dstE  = dste;
        d_dstM  = 4'hF;
        d_stat  = stat;
    endtask

    task automatic nop_d();
        set_d(4'h1, 4'h0, 64'h0, 64'h0, 4'hF, 2'd0);
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        e_stall = 1'b0; e_bubble = 1'b0; m_bubble = 1'b0; m_exc = 1'b0; w_exc = 1'b0;
        nop_d();
        #12;
        chk("rst_M_icode", M_icode, 4'h1);
        chk("rst_M_dstE", M_dstE, 4'hF);
        chk("rst_cc", cc, 3'b100);
        chk("rst_halted", halted, 1'b0);
        chk("rst_e_valE", e_valE, 64'h0);
        chk("rst_e_dstE", e_dstE, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // OPq sub 50-30
        set_d(4'h6, 4'h1, 64'd30, 64'd50, 4'h3, 2'd0);
        step();
        chk("sub_e_valE", e_valE, 64'd20);
        chk("sub_cc_before", cc, 3'b100);
        nop_d();
        step();
        chk("sub_cc_after", cc, 3'b000);
        chk("sub_M_valE", M_valE, 64'd20);
        chk("sub_M_icode", M_icode, 4'h6);
        chk("sub_M_dstE", M_dstE, 4'h3);

        // OPq sub 30-50 then jle
        set_d(4'h6, 4'h1, 64'd50, 64'd30, 4'h3, 2'd0);
        step();
        chk("neg_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFEC);
        set_d(4'h7, 4'h1, 64'h0, 64'h0, 4'hF, 2'd0);
        step();
        chk("neg_cc", cc, 3'b010);
        nop_d();
        step();
        chk("jle_M_icode", M_icode, 4'h7);
        chk("jle_M_Cnd", M_Cnd, 1'b1);

        // Add overflow
        set_d(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, 2'd0);
        step();
        chk("ovf_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        nop_d();
        step();
        chk("ovf_cc", cc, 3'b011);

        // xor to set ZF, then cmovne and push
        set_d(4'h6, 4'h3, 64'd5, 64'd5, 4'h3, 2'd0);
        step();
        set_d(4'h2, 4'h4, 64'h55, 64'h0, 4'h5, 2'd0);
        step();
        chk("xor_cc", cc, 3'b100);
        chk("cmovne_e_dstE", e_dstE, 4'hF);
        chk("cmovne_e_valE", e_valE, 64'h55);
        set_d(4'hA, 4'h0, 64'h0, 64'h100, 4'h4, 2'd0);
        step();
        chk("push_e_valE", e_valE, 64'hF8);
        chk("push_e_dstE", e_dstE, 4'h4);

        // E stall for two cycles
        set_d(4'h6, 4'h0, 64'd1, 64'd2, 4'h6, 2'd0);
        e_stall = 1'b1;
        step();
        chk("stall1_e_valE", e_valE, 64'hF8);
        step();
        chk("stall2_e_valE", e_valE, 64'hF8);
        e_stall = 1'b0;
        step();
        chk("unstall_e_valE", e_valE, 64'd3);
        chk("unstall_cc", cc, 3'b100);
        chk("unstall_M_icode", M_icode, 4'hA);

        // Load-use: E holds, M bubbles
        e_stall = 1'b1;
        m_bubble = 1'b1;
        step();
        chk("lu_e_valE", e_valE, 64'd3);
        chk("lu_M_icode", M_icode, 4'h1);
        chk("lu_M_dstE", M_dstE, 4'hF);
        chk("lu_M_stat", M_stat, 2'd0);
        e_stall = 1'b0;
        m_bubble = 1'b0;

        // OPq leaving E while W holds an exception must not write CC
        set_d(4'h6, 4'h3, 64'd7, 64'd7, 4'h3, 2'd0);
        step();
        chk("pre_wexc_cc", cc, 3'b000);
        w_exc = 1'b1;
        nop_d();
        step();
        chk("wexc_cc", cc, 3'b000);
        chk("wexc_M_icode", M_icode, 4'h6);
        w_exc = 1'b0;

        // Halt instruction reaches M, then everything freezes
        set_d(4'h0, 4'h0, 64'h0, 64'h0, 4'hF, 2'd1);
        step();
        set_d(4'h6, 4'h3, 64'd9, 64'd9, 4'h3, 2'd0);
        step();
        chk("hlt_M_stat", M_stat, 2'd1);
        chk("hlt_M_icode", M_icode, 4'h0);
        chk("hlt_halted", halted, 1'b1);
        step();
        chk("hlt_cc_frozen", cc, 3'b000);
        chk("hlt_M_bubble", M_icode, 4'h1);
        chk("hlt_M_stat_bub", M_stat, 2'd0);
        step();
        chk("hlt_still", halted, 1'b1);
        chk("hlt_e_valE_bub", e_valE, 64'h0);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cc", cc, 3'b100);
        chk("arst_halted", halted, 1'b0);
        chk("arst_M_icode", M_icode, 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
